// File: rtl/tap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tap_pkg
//  Description : Shared definitions for the JTAG TAP controller: TAP state
//                enumeration, IR width, instruction opcodes, select-vector
//                bit positions and the instruction decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package tap_pkg;

    localparam int IR_WIDTH = 4;

    // IEEE 1149.1 TAP controller states
    typedef enum logic [3:0] {
        TEST_LOGIC_RESET = 4'h0,
        RUN_TEST_IDLE    = 4'h1,
        SELECT_DR        = 4'h2,
        CAPTURE_DR       = 4'h3,
        SHIFT_DR         = 4'h4,
        EXIT1_DR         = 4'h5,
        PAUSE_DR         = 4'h6,
        EXIT2_DR         = 4'h7,
        UPDATE_DR        = 4'h8,
        SELECT_IR        = 4'h9,
        CAPTURE_IR       = 4'hA,
        SHIFT_IR         = 4'hB,
        EXIT1_IR         = 4'hC,
        PAUSE_IR         = 4'hD,
        EXIT2_IR         = 4'hE,
        UPDATE_IR        = 4'hF
    } tap_state_t;

    // Instruction opcodes
    localparam logic [IR_WIDTH-1:0] c_OP_EXTEST   = 4'b0000;
    localparam logic [IR_WIDTH-1:0] c_OP_IDCODE   = 4'b0001;
    localparam logic [IR_WIDTH-1:0] c_OP_SAMPLE   = 4'b0010;
    localparam logic [IR_WIDTH-1:0] c_OP_INTEST   = 4'b0011;
    localparam logic [IR_WIDTH-1:0] c_OP_USERCODE = 4'b0100;
    localparam logic [IR_WIDTH-1:0] c_OP_RUNBIST  = 4'b0101;
    localparam logic [IR_WIDTH-1:0] c_OP_GETTEST  = 4'b0110;
    localparam logic [IR_WIDTH-1:0] c_OP_SETSTATE = 4'b0111;
    localparam logic [IR_WIDTH-1:0] c_OP_BYPASS   = 4'b1111;

    // Bit positions inside the one-hot select vector
    localparam int c_SEL_IDCODE   = 0;
    localparam int c_SEL_SAMPLE   = 1;
    localparam int c_SEL_EXTEST   = 2;
    localparam int c_SEL_INTEST   = 3;
    localparam int c_SEL_USERCODE = 4;
    localparam int c_SEL_RUNBIST  = 5;
    localparam int c_SEL_GETTEST  = 6;
    localparam int c_SEL_SETSTATE = 7;
    localparam int c_SEL_COUNT    = 8;

    // One-hot decode; BYPASS and every unassigned code give all zeros
    function automatic logic [c_SEL_COUNT-1:0] decode_instr(input logic [IR_WIDTH-1:0] op);
        logic [c_SEL_COUNT-1:0] sel;
        sel = '0;
        case (op)
            c_OP_IDCODE:   sel[c_SEL_IDCODE]   = 1'b1;
            c_OP_SAMPLE:   sel[c_SEL_SAMPLE]   = 1'b1;
            c_OP_EXTEST:   sel[c_SEL_EXTEST]   = 1'b1;
            c_OP_INTEST:   sel[c_SEL_INTEST]   = 1'b1;
            c_OP_USERCODE: sel[c_SEL_USERCODE] = 1'b1;
            c_OP_RUNBIST:  sel[c_SEL_RUNBIST]  = 1'b1;
            c_OP_GETTEST:  sel[c_SEL_GETTEST]  = 1'b1;
            c_OP_SETSTATE: sel[c_SEL_SETSTATE] = 1'b1;
            default:       sel = '0;
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tap_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tap_fsm
//  Description : 16-state IEEE 1149.1 TAP state machine. State advances on
//                the rising edge of TCK under control of TMS; TRST_N forces
//                TEST_LOGIC_RESET asynchronously.
//  Revision    : 1.0 - initial release
// ============================================================================
module tap_fsm
    import tap_pkg::*;
(
    input  logic       TCK,
    input  logic       TRST_N,
    input  logic       TMS,
    output tap_state_t state
);

    // Standard TAP next-state transitions
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            state <= TEST_LOGIC_RESET;
        end else begin
            unique case (state)
                TEST_LOGIC_RESET: state <= TMS ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
                RUN_TEST_IDLE:    state <= TMS ? SELECT_DR        : RUN_TEST_IDLE;
                SELECT_DR:        state <= TMS ? SELECT_IR        : CAPTURE_DR;
                CAPTURE_DR:       state <= TMS ? EXIT1_DR         : SHIFT_DR;
                SHIFT_DR:         state <= TMS ? EXIT1_DR         : SHIFT_DR;
                EXIT1_DR:         state <= TMS ? UPDATE_DR        : PAUSE_DR;
                PAUSE_DR:         state <= TMS ? EXIT2_DR         : PAUSE_DR;
                EXIT2_DR:         state <= TMS ? UPDATE_DR        : SHIFT_DR;
                UPDATE_DR:        state <= TMS ? SELECT_DR        : RUN_TEST_IDLE;
                SELECT_IR:        state <= TMS ? TEST_LOGIC_RESET : CAPTURE_IR;
                CAPTURE_IR:       state <= TMS ? EXIT1_IR         : SHIFT_IR;
                SHIFT_IR:         state <= TMS ? EXIT1_IR         : SHIFT_IR;
                EXIT1_IR:         state <= TMS ? UPDATE_IR        : PAUSE_IR;
                PAUSE_IR:         state <= TMS ? EXIT2_IR         : PAUSE_IR;
                EXIT2_IR:         state <= TMS ? UPDATE_IR        : SHIFT_IR;
                UPDATE_IR:        state <= TMS ? SELECT_DR        : RUN_TEST_IDLE;
                default:          state <= TEST_LOGIC_RESET;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/tap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tap_ctrl
//  Description : JTAG TAP controller top. Hosts the instruction register
//                (shift stage + update latch), instruction decode, bypass
//                register and the TDO output multiplexer; the state machine
//                lives in tap_fsm.
//  Revision    : 1.0 - initial release
// ============================================================================
module tap_ctrl
    import tap_pkg::*;
#(
    parameter int                  IR_WIDTH   = 4,
    parameter logic [IR_WIDTH-1:0] IR_CAPTURE = 4'b0001
)(
    input  logic TCK,
    input  logic TRST_N,
    input  logic TMS,
    input  logic TDI,
    input  logic ID_REG_TDO,
    input  logic USERCODE_REG_TDO,
    input  logic BSR_TDO,
    output logic CAPTUREDR,
    output logic SHIFTDR,
    output logic UPDATEDR,
    output logic IDCODE_SELECT,
    output logic SAMPLE_SELECT,
    output logic EXTEST_SELECT,
    output logic INTEST_SELECT,
    output logic USERCODE_SELECT,
    output logic RUNBIST_SELECT,
    output logic GETTEST_SELECT,
    output logic SETSTATE_SELECT,
    output logic TDO,
    output logic TDO_EN
);

    // Capture pattern with the two LSBs forced to 01 regardless of override
    localparam logic [IR_WIDTH-1:0] c_IR_CAPTURE = {IR_CAPTURE[IR_WIDTH-1:2], 2'b01};

    tap_state_t             w_state;
    logic [IR_WIDTH-1:0]    r_ir_shift;
    logic [IR_WIDTH-1:0]    r_ir_upd;
    logic [c_SEL_COUNT-1:0] w_sel;
    logic                   w_is_bypass;
    logic                   r_bypass;
    logic                   r_tdo_q;
    logic                   r_tdo_en;
    logic                   r_tdo_dr_path;
    logic                   w_tdo_dr;

    tap_fsm u_fsm (
        .TCK    (TCK),
        .TRST_N (TRST_N),
        .TMS    (TMS),
        .state  (w_state)
    );

    // DR-stage strobes are plain state decodes
    assign CAPTUREDR = (w_state == CAPTURE_DR);
    assign SHIFTDR   = (w_state == SHIFT_DR);
    assign UPDATEDR  = (w_state == UPDATE_DR);

    // IR shift stage: capture on CAPTURE_IR, shift LSB-out / TDI-in on SHIFT_IR
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            r_ir_shift <= c_IR_CAPTURE;
        end else if (w_state == CAPTURE_IR) begin
            r_ir_shift <= c_IR_CAPTURE;
        end else if (w_state == SHIFT_IR) begin
            r_ir_shift <= {TDI, r_ir_shift[IR_WIDTH-1:1]};
        end
    end

    // IR update latch: falling edge so the new instruction is stable before
    // the next rising edge; TEST_LOGIC_RESET restores IDCODE
    always_ff @(negedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            r_ir_upd <= c_OP_IDCODE;
        end else if (w_state == TEST_LOGIC_RESET) begin
            r_ir_upd <= c_OP_IDCODE;
        end else if (w_state == UPDATE_IR) begin
            r_ir_upd <= r_ir_shift;
        end
    end

    assign w_sel       = decode_instr(r_ir_upd);
    assign w_is_bypass = ~|w_sel;

    assign IDCODE_SELECT   = w_sel[c_SEL_IDCODE];
    assign SAMPLE_SELECT   = w_sel[c_SEL_SAMPLE];
    assign EXTEST_SELECT   = w_sel[c_SEL_EXTEST];
    assign INTEST_SELECT   = w_sel[c_SEL_INTEST];
    assign USERCODE_SELECT = w_sel[c_SEL_USERCODE];
    assign RUNBIST_SELECT  = w_sel[c_SEL_RUNBIST];
    assign GETTEST_SELECT  = w_sel[c_SEL_GETTEST];
    assign SETSTATE_SELECT = w_sel[c_SEL_SETSTATE];

    // Single-bit bypass register, only live while BYPASS is decoded
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            r_bypass <= 1'b0;
        end else if (w_is_bypass) begin
            if (w_state == CAPTURE_DR) begin
                r_bypass <= 1'b0;
            end else if (w_state == SHIFT_DR) begin
                r_bypass <= TDI;
            end
        end
    end

    // Falling-edge TDO registers: enable, internal serial bit and path choice
    always_ff @(negedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            r_tdo_en      <= 1'b0;
            r_tdo_q       <= 1'b0;
            r_tdo_dr_path <= 1'b0;
        end else begin
            r_tdo_en      <= (w_state == SHIFT_IR) || (w_state == SHIFT_DR);
            r_tdo_dr_path <= (w_state == SHIFT_DR) && !w_is_bypass;
            if (w_state == SHIFT_IR) begin
                r_tdo_q <= r_ir_shift[0];
            end else if ((w_state == SHIFT_DR) && w_is_bypass) begin
                r_tdo_q <= r_bypass;
            end else begin
                r_tdo_q <= 1'b0;
            end
        end
    end

    // External DR-stage registers are passed straight through
    always_comb begin
        w_tdo_dr = BSR_TDO;
        if (w_sel[c_SEL_IDCODE]) begin
            w_tdo_dr = ID_REG_TDO;
        end else if (w_sel[c_SEL_USERCODE]) begin
            w_tdo_dr = USERCODE_REG_TDO;
        end
    end

    assign TDO    = r_tdo_en & (r_tdo_dr_path ? w_tdo_dr : r_tdo_q);
    assign TDO_EN = r_tdo_en;

endmodule
`default_nettype wire

// File: tb/tb_tap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tap_ctrl
//  Description : Self-checking bench for tap_ctrl. A table-driven TAP model
//                plus an emulated DR stage predict every output each cycle;
//                directed scans add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tap_ctrl;
    import tap_pkg::*;

    logic TCK = 1'b0;
    logic TRST_N = 1'b1;
    logic TMS = 1'b1;
    logic TDI = 1'b0;
    logic ID_REG_TDO, USERCODE_REG_TDO, BSR_TDO;
    logic CAPTUREDR, SHIFTDR, UPDATEDR;
    logic IDCODE_SELECT, SAMPLE_SELECT, EXTEST_SELECT, INTEST_SELECT;
    logic USERCODE_SELECT, RUNBIST_SELECT, GETTEST_SELECT, SETSTATE_SELECT;
    logic TDO, TDO_EN;
    logic [7:0] dut_sel;

    int n_chk = 0;
    int n_err = 0;
    int n_shift = 0;
    int n_upd = 0;
    logic chk_en = 1'b0;

    // DR-stage environment (8-bit registers, LSB shifted out first)
    logic [7:0] id_sr   = 8'hA1;
    logic [7:0] user_sr = 8'h5C;
    logic [7:0] bsr_sr  = 8'h93;
    assign ID_REG_TDO       = id_sr[0];
    assign USERCODE_REG_TDO = user_sr[0];
    assign BSR_TDO          = bsr_sr[0];

    assign dut_sel = {SETSTATE_SELECT, GETTEST_SELECT, RUNBIST_SELECT, USERCODE_SELECT,
                      INTEST_SELECT, EXTEST_SELECT, SAMPLE_SELECT, IDCODE_SELECT};

    tap_ctrl dut (
        .TCK              (TCK),
        .TRST_N           (TRST_N),
        .TMS              (TMS),
        .TDI              (TDI),
        .ID_REG_TDO       (ID_REG_TDO),
        .USERCODE_REG_TDO (USERCODE_REG_TDO),
        .BSR_TDO          (BSR_TDO),
        .CAPTUREDR        (CAPTUREDR),
        .SHIFTDR          (SHIFTDR),
        .UPDATEDR         (UPDATEDR),
        .IDCODE_SELECT    (IDCODE_SELECT),
        .SAMPLE_SELECT    (SAMPLE_SELECT),
        .EXTEST_SELECT    (EXTEST_SELECT),
        .INTEST_SELECT    (INTEST_SELECT),
        .USERCODE_SELECT  (USERCODE_SELECT),
        .RUNBIST_SELECT   (RUNBIST_SELECT),
        .GETTEST_SELECT   (GETTEST_SELECT),
        .SETSTATE_SELECT  (SETSTATE_SELECT),
        .TDO              (TDO),
        .TDO_EN           (TDO_EN)
    );

    always #5 TCK = ~TCK;

    // ---------------- model ----------------
    tap_state_t nx0 [16];
    tap_state_t nx1 [16];
    int         sel_idx [16];
    tap_state_t m_st;
    logic [3:0] m_irs, m_iru;
    logic       m_byp;

    initial begin
        nx0[TEST_LOGIC_RESET] = RUN_TEST_IDLE; nx1[TEST_LOGIC_RESET] = TEST_LOGIC_RESET;
        nx0[RUN_TEST_IDLE]    = RUN_TEST_IDLE; nx1[RUN_TEST_IDLE]    = SELECT_DR;
        nx0[SELECT_DR]  = CAPTURE_DR;    nx1[SELECT_DR]  = SELECT_IR;
        nx0[CAPTURE_DR] = SHIFT_DR;      nx1[CAPTURE_DR] = EXIT1_DR;
        nx0[SHIFT_DR]   = SHIFT_DR;      nx1[SHIFT_DR]   = EXIT1_DR;
        nx0[EXIT1_DR]   = PAUSE_DR;      nx1[EXIT1_DR]   = UPDATE_DR;
        nx0[PAUSE_DR]   = PAUSE_DR;      nx1[PAUSE_DR]   = EXIT2_DR;
        nx0[EXIT2_DR]   = SHIFT_DR;      nx1[EXIT2_DR]   = UPDATE_DR;
        nx0[UPDATE_DR]  = RUN_TEST_IDLE; nx1[UPDATE_DR]  = SELECT_DR;
        nx0[SELECT_IR]  = CAPTURE_IR;    nx1[SELECT_IR]  = TEST_LOGIC_RESET;
        nx0[CAPTURE_IR] = SHIFT_IR;      nx1[CAPTURE_IR] = EXIT1_IR;
        nx0[SHIFT_IR]   = SHIFT_IR;      nx1[SHIFT_IR]   = EXIT1_IR;
        nx0[EXIT1_IR]   = PAUSE_IR;      nx1[EXIT1_IR]   = UPDATE_IR;
        nx0[PAUSE_IR]   = PAUSE_IR;      nx1[PAUSE_IR]   = EXIT2_IR;
        nx0[EXIT2_IR]   = SHIFT_IR;      nx1[EXIT2_IR]   = UPDATE_IR;
        nx0[UPDATE_IR]  = RUN_TEST_IDLE; nx1[UPDATE_IR]  = SELECT_DR;
        for (int k = 0; k < 16; k++) sel_idx[k] = -1;
        sel_idx[0] = 2; sel_idx[1] = 0; sel_idx[2] = 1; sel_idx[3] = 3;
        sel_idx[4] = 4; sel_idx[5] = 5; sel_idx[6] = 6; sel_idx[7] = 7;
    end

    task automatic m_reset();
        m_st  = TEST_LOGIC_RESET;
        m_irs = 4'b0001;
        m_iru = 4'b0001;
        m_byp = 1'b0;
    endtask

    function automatic logic [7:0] exp_sel(input logic [3:0] op);
        int k;
        k = sel_idx[op];
        return (k < 0) ? 8'd0 : 8'(1 << k);
    endfunction

    // Bit the selected scan path currently presents (0 outside shift states)
    function automatic logic model_tdo();
        if (m_st == SHIFT_IR) return m_irs[0];
        if (m_st != SHIFT_DR) return 1'b0;
        if (sel_idx[m_iru] < 0) return m_byp;
        if (m_iru == 4'b0001) return id_sr[0];
        if (m_iru == 4'b0100) return user_sr[0];
        return bsr_sr[0];
    endfunction

    always @(posedge TCK) begin
        if (TRST_N) begin
            if (m_st == CAPTURE_DR) begin
                id_sr = 8'hA1; user_sr = 8'h5C; bsr_sr = 8'h93;
                if (sel_idx[m_iru] < 0) m_byp = 1'b0;
            end
            if (m_st == SHIFT_DR) begin
                id_sr   = {TDI, id_sr[7:1]};
                user_sr = {TDI, user_sr[7:1]};
                bsr_sr  = {TDI, bsr_sr[7:1]};
                if (sel_idx[m_iru] < 0) m_byp = TDI;
            end
            if (m_st == CAPTURE_IR) m_irs = 4'b0001;
            if (m_st == SHIFT_IR)   m_irs = {TDI, m_irs[3:1]};
            m_st = TMS ? nx1[m_st] : nx0[m_st];
        end
    end

    always @(negedge TCK) begin
        if (TRST_N) begin
            if (m_st == UPDATE_IR)             m_iru = m_irs;
            else if (m_st == TEST_LOGIC_RESET) m_iru = 4'b0001;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge TCK) begin
        #1;
        if (chk_en) begin
            logic en_exp;
            en_exp = (m_st == SHIFT_IR) || (m_st == SHIFT_DR);
            check("state", 32'(dut.w_state), 32'(m_st));
            check("strobes", 32'({CAPTUREDR, SHIFTDR, UPDATEDR}),
                  32'({m_st == CAPTURE_DR, m_st == SHIFT_DR, m_st == UPDATE_DR}));
            check("selects", 32'(dut_sel), 32'(exp_sel(m_iru)));
            check("tdo_en", 32'(TDO_EN), 32'(en_exp));
            check("tdo", 32'(TDO), 32'(model_tdo()));
            if (SHIFTDR)  n_shift++;
            if (UPDATEDR) n_upd++;
        end
    end

    // ---------------- stimulus ----------------
    // Drive after a falling edge, return 3ns after the following falling edge
    task automatic tick(input logic tms, input logic tdi = 1'b0);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        @(negedge TCK);
        #3;
    endtask

    task automatic to_shift_dr();
        tick(1'b1); tick(1'b0); tick(1'b0);
    endtask

    task automatic load_ir(input logic [3:0] op);
        tick(1'b1); tick(1'b1); tick(1'b0); tick(1'b0);
        for (int i = 0; i < 4; i++) tick(i == 3, op[i]);
        tick(1'b1);
        tick(1'b0);
    endtask

    initial begin
        logic [3:0] ir_exp;
        logic [7:0] id_exp;
        logic [3:0] byp_in, byp_exp, bsr_in;

        #1;
        TRST_N = 1'b0;
        m_reset();
        @(negedge TCK);
        #3;
        TRST_N = 1'b1;
        chk_en = 1'b1;
        check("rst_state", 32'(dut.w_state), 32'(TEST_LOGIC_RESET));
        check("rst_selects", 32'(dut_sel), 32'h01);
        check("rst_tdo_en", 32'(TDO_EN), 32'd0);
        check("rst_tdo", 32'(TDO), 32'd0);
        tick(1'b0);

        // IR scan of SAMPLE; captured 0001 appears on TDO LSB first
        ir_exp = 4'b0001;
        tick(1'b1); tick(1'b1); tick(1'b0); tick(1'b0);
        for (int i = 0; i < 4; i++) begin
            check("ir_tdo", 32'(TDO), 32'(ir_exp[i]));
            tick(i == 3, (i == 1));
        end
        tick(1'b1);
        check("sample_sel", 32'(SAMPLE_SELECT), 32'd1);
        check("sample_onehot", 32'(dut_sel), 32'h02);
        tick(1'b0);

        // Five TMS=1 edges out of SHIFT_DR land in TEST_LOGIC_RESET
        to_shift_dr();
        check("in_shiftdr", 32'(SHIFTDR), 32'd1);
        repeat (5) tick(1'b1);
        check("tlr_state", 32'(dut.w_state), 32'(TEST_LOGIC_RESET));
        check("tlr_idcode", 32'(IDCODE_SELECT), 32'd1);
        tick(1'b0);

        // IDCODE scan through external ID register
        load_ir(4'b0001);
        to_shift_dr();
        id_exp = 8'hA1;
        for (int i = 0; i < 8; i++) begin
            check("id_tdo", 32'(TDO), 32'(id_exp[i]));
            tick(i == 7, 1'b0);
        end
        tick(1'b1); tick(1'b0);

        // Undefined opcode acts as BYPASS with one-cycle delay
        load_ir(4'b1010);
        check("undef_selects", 32'(dut_sel), 32'h00);
        to_shift_dr();
        byp_in  = 4'b1101;
        byp_exp = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            check("byp_tdo", 32'(TDO), 32'(byp_exp[i]));
            tick(i == 3, byp_in[i]);
        end
        tick(1'b1); tick(1'b0);

        // IR scan interrupted by a pause; instruction held until update
        tick(1'b1); tick(1'b1); tick(1'b0); tick(1'b0);
        tick(1'b0, 1'b1); tick(1'b1, 1'b1);
        tick(1'b0);
        check("pause_ir_hold", 32'(dut_sel), 32'h00);
        tick(1'b0); tick(1'b1); tick(1'b0);
        tick(1'b0, 1'b1); tick(1'b1, 1'b0);
        tick(1'b1);
        check("setstate_sel", 32'(dut_sel), 32'h80);
        tick(1'b0);

        // BSR path under SETSTATE
        to_shift_dr();
        bsr_in = 4'b1001;
        for (int i = 0; i < 4; i++) tick(i == 3, bsr_in[i]);
        tick(1'b1); tick(1'b0);

        // EXTEST scan with pause: 3 + 7 shift cycles, one update
        load_ir(4'b0000);
        check("extest_sel", 32'(dut_sel), 32'h04);
        n_shift = 0;
        n_upd   = 0;
        tick(1'b1); tick(1'b0); tick(1'b0);
        tick(1'b0); tick(1'b0); tick(1'b1);
        tick(1'b0); repeat (3) tick(1'b0); tick(1'b1);
        tick(1'b0); repeat (6) tick(1'b0, 1'b1); tick(1'b1);
        tick(1'b1); tick(1'b0);
        check("shiftdr_count", 32'(n_shift), 32'd10);
        check("updatedr_count", 32'(n_upd), 32'd1);

        // Reset asserted in the middle of a USERCODE DR scan
        load_ir(4'b0100);
        check("usercode_sel", 32'(dut_sel), 32'h10);
        to_shift_dr();
        tick(1'b0, 1'b1); tick(1'b0, 1'b0);
        n_upd = 0;
        TRST_N = 1'b0;
        m_reset();
        #1;
        check("trst_state", 32'(dut.w_state), 32'(TEST_LOGIC_RESET));
        check("trst_tdo_en", 32'(TDO_EN), 32'd0);
        check("trst_idcode", 32'(IDCODE_SELECT), 32'd1);
        check("trst_updatedr", 32'(UPDATEDR), 32'd0);
        #1;
        TRST_N = 1'b1;
        tick(1'b1); tick(1'b1); tick(1'b0); tick(1'b0);
        check("trst_no_update", 32'(n_upd), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tap_ctrl.md
TAP_CTRL -- requirements
Module: tap_ctrl

Interface
REQ-001 Parameter: IR_WIDTH, 4, instruction register length in bits.
REQ-002 Parameter: IR_CAPTURE, 4'b0001, value loaded into the IR shift stage in CAPTURE_IR; the two LSBs are fixed at 01.
REQ-003 The block SHALL use one clock, TCK; reset is asynchronous and active-low on TRST_N.
REQ-004 Ports:
- TCK  in  1  test clock.
- TRST_N  in  1  async active-low reset.
- TMS  in  1  mode select, sampled on posedge TCK.
- TDI  in  1  serial data in.
- ID_REG_TDO, USERCODE_REG_TDO, BSR_TDO  in  1 each  serial outputs of the DR stage.
- CAPTUREDR, SHIFTDR, UPDATEDR  out  1 each  DR-stage strobes.
- IDCODE_SELECT, SAMPLE_SELECT, EXTEST_SELECT, INTEST_SELECT, USERCODE_SELECT, RUNBIST_SELECT, GETTEST_SELECT, SETSTATE_SELECT  out  1 each  decoded instruction.
- TDO  out  1  serial data out.
- TDO_EN  out  1  TDO drive enable.

Function
REQ-005 The controller SHALL implement the 16-state IEEE 1149.1 TAP FSM: TEST_LOGIC_RESET, RUN_TEST_IDLE, SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR, and the corresponding _IR states. Transitions occur on posedge TCK per TMS, as in the standard.
REQ-006 Five consecutive TMS=1 posedges from any state SHALL reach TEST_LOGIC_RESET.
REQ-007 CAPTUREDR, SHIFTDR and UPDATEDR SHALL each be a combinational decode of the current state: high exactly while the state is CAPTURE_DR, SHIFT_DR and UPDATE_DR respectively.
- The DR stage acts on the posedge ending that state.
REQ-008 IR shift stage (IR_WIDTH bits) behaviour on posedge:
- In CAPTURE_IR: load IR_CAPTURE.
- In SHIFT_IR: shift right, TDI into the MSB.
- Otherwise: hold.
REQ-009 IR update register SHALL load the shift stage on the negedge TCK while in UPDATE_IR, and SHALL load 4'b0001 (IDCODE) whenever the state is TEST_LOGIC_RESET.
REQ-010 Opcode decode:
- EXTEST 0000, IDCODE 0001, SAMPLE 0010, INTEST 0011, USERCODE 0100, RUNBIST 0101, GETTEST 0110, SETSTATE 0111, BYPASS 1111.
- Any other code decodes as BYPASS.
REQ-011 The select outputs SHALL be one-hot or all-zero: exactly one select is high for a non-BYPASS code, and all selects are low for BYPASS.
REQ-012 Bypass register: 1 bit; cleared on posedge in CAPTURE_DR; loads TDI on posedge in SHIFT_DR; active only when the decode is BYPASS.
REQ-013 TDO path:
- In SHIFT_IR: IR shift-stage bit 0, registered on negedge TCK.
- In SHIFT_DR with BYPASS: bypass bit, registered on negedge TCK.
- In SHIFT_DR with IDCODE: ID_REG_TDO passes combinationally.
- In SHIFT_DR with USERCODE: USERCODE_REG_TDO passes combinationally.
- In SHIFT_DR with any other instruction: BSR_TDO passes combinationally.
REQ-014 TDO_EN SHALL be registered on negedge TCK, high iff the state is SHIFT_IR or SHIFT_DR. While TDO_EN is low, TDO SHALL be 0.
REQ-015 Changing TMS mid-SHIFT (leaving via EXIT1 then PAUSE) SHALL retain both the IR shift stage and the IR update contents.

Reset
REQ-016 TRST_N low SHALL asynchronously force:
- State to TEST_LOGIC_RESET.
- IR update register to 0001, so IDCODE_SELECT=1 and all other selects 0.
- IR shift stage to IR_CAPTURE.
- Bypass register, TDO and TDO_EN to 0.
REQ-017 Reset asserted mid-scan SHALL abort the scan; no UPDATE strobe SHALL be generated.

Structure
REQ-018 A shared package tap_pkg SHALL hold the TAP state enumeration, the opcode constants and IR_WIDTH; the DR stage imports the same opcodes.
REQ-019 The FSM SHALL be a sub-module tap_fsm (TCK, TRST_N, TMS -> state). Decode, IR, bypass and the TDO mux stay in tap_ctrl.

Verification
REQ-020 From SHIFT_DR, drive five TMS=1 edges -> state is TEST_LOGIC_RESET and IDCODE_SELECT=1.
REQ-021 Scan IR with 0010 (LSB first) -> TDO shows 1,0,0,0 during SHIFT_IR; after UPDATE_IR, SAMPLE_SELECT=1 and all other selects are 0.
REQ-022 With IR=IDCODE, capture and shift 8 bits, DR stage ID=8'hA1 -> TDO sequence 1,0,0,0,0,1,0,1.
REQ-023 With IR=1010 (undefined) -> all selects are 0; shifting 1,0,1,1 yields TDO 0,1,0,1 (one-cycle bypass delay).
REQ-024 Pulse TRST_N low during SHIFT_DR under USERCODE -> immediate TEST_LOGIC_RESET, TDO_EN=0, no UPDATEDR pulse, IDCODE_SELECT=1.
REQ-025 With IR=EXTEST, Capture -> Shift(3) -> Exit1 -> Pause(4) -> Exit2 -> Shift(7) -> Update -> exactly 10 SHIFTDR-high cycles and one UPDATEDR-high cycle.
